// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder: digit-serial adder/subtractor, DIGIT bits per clock, rev 1.0
// ============================================================================

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic               amsb_q, amsb_d;
  logic               bmsb_q, bmsb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT:0]     dig_sum;
  logic [WIDTH-1:0]   part_next;

  assign dig_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, cy_q};

  // New digit enters at the top so the last digit leaves the word LSB-aligned.
  assign part_next = (part_q >> DIGIT)
                   | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_BUSY;
          a_d     = a_i;
          b_d     = b_i ^ {WIDTH{sub_i}};
          cy_d    = cin_i ^ sub_i;
          cnt_d   = '0;
          part_d  = '0;
          amsb_d  = a_i[WIDTH-1];
          bmsb_d  = b_i[WIDTH-1] ^ sub_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        part_d = part_next;
        cy_d   = dig_sum[DIGIT];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = part_next;
          carry_d = dig_sum[DIGIT];
          ovf_d   = (amsb_q == bmsb_q) && (part_next[WIDTH-1] != amsb_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o  = (state_q == S_BUSY);
  assign done_o  = (state_q == S_DONE);
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_serial_adder: directed bench for serial_adder at 8/1, 16/4 and 8/8, rev 1.0
// ============================================================================

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // WIDTH=8, DIGIT=1
  logic       st8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  // WIDTH=16, DIGIT=4
  logic        st16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, carry16, ovf16;
  logic [15:0] sum16;

  // WIDTH=8, DIGIT=8
  logic       st88 = 1'b0, cin88 = 1'b0, sub88 = 1'b0;
  logic [7:0] a88 = '0, b88 = '0;
  logic       busy88, done88, carry88, ovf88;
  logic [7:0] sum88;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start_i(st8), .a_i(a8), .b_i(b8),
    .cin_i(cin8), .sub_i(sub8), .busy_o(busy8), .done_o(done8),
    .sum_o(sum8), .carry_o(carry8), .ovf_o(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start_i(st16), .a_i(a16), .b_i(b16),
    .cin_i(cin16), .sub_i(sub16), .busy_o(busy16), .done_o(done16),
    .sum_o(sum16), .carry_o(carry16), .ovf_o(ovf16)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d88 (
    .clk(clk), .rst_n(rst_n), .start_i(st88), .a_i(a88), .b_i(b88),
    .cin_i(cin88), .sub_i(sub88), .busy_o(busy88), .done_o(done88),
    .sum_o(sum88), .carry_o(carry88), .ovf_o(ovf88)
  );

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full 8/1 operation: start edge, eight busy cycles, done pulse, then idle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, input logic [7:0] es, input logic ec,
                      input logic eo, input string tag);
    a8 = a; b8 = b; cin8 = c; sub8 = s; st8 = 1'b1;
    step();
    st8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " busy"}, {31'b0, busy8}, 32'd1);
      chk({tag, " early done"}, {31'b0, done8}, 32'd0);
      step();
    end
    chk({tag, " done"}, {31'b0, done8}, 32'd1);
    chk({tag, " busy at done"}, {31'b0, busy8}, 32'd0);
    chk({tag, " sum"}, {24'b0, sum8}, {24'b0, es});
    chk({tag, " carry"}, {31'b0, carry8}, {31'b0, ec});
    chk({tag, " ovf"}, {31'b0, ovf8}, {31'b0, eo});
    step();
    chk({tag, " done drop"}, {31'b0, done8}, 32'd0);
    chk({tag, " sum hold"}, {24'b0, sum8}, {24'b0, es});
  endtask

  initial begin
    logic saw_done;

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst busy", {31'b0, busy8}, 32'd0);
    chk("rst done", {31'b0, done8}, 32'd0);
    chk("rst sum", {24'b0, sum8}, 32'd0);
    chk("rst carry", {31'b0, carry8}, 32'd0);
    chk("rst ovf", {31'b0, ovf8}, 32'd0);

    run8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add5A3C");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "addFF01");
    run8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "sub1020");
    run8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub8001");
    run8(8'h0F, 8'h01, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0, "subcin");

    // Starts during BUSY cycles 2 and 5 must be ignored.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; st8 = 1'b1;
    step();
    st8 = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2 || k == 5) begin
        a8 = 8'hA5; b8 = 8'h77; cin8 = 1'b1; sub8 = 1'b1; st8 = 1'b1;
      end else begin
        st8 = 1'b0;
      end
      chk("ign sum hold", {24'b0, sum8}, 32'h0D);
      if (done8) saw_done = 1'b1;
      step();
    end
    st8 = 1'b0;
    chk("ign early done", {31'b0, saw_done}, 32'd0);
    chk("ign done", {31'b0, done8}, 32'd1);
    chk("ign sum", {24'b0, sum8}, 32'h46);
    chk("ign carry", {31'b0, carry8}, 32'd0);
    step();
    chk("ign single done", {31'b0, done8}, 32'd0);
    chk("ign no restart", {31'b0, busy8}, 32'd0);

    // Reset in the middle of BUSY aborts without a done pulse.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; st8 = 1'b1;
    step();
    st8 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort busy", {31'b0, busy8}, 32'd0);
    chk("abort sum", {24'b0, sum8}, 32'd0);
    chk("abort carry", {31'b0, carry8}, 32'd0);
    chk("abort ovf", {31'b0, ovf8}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) saw_done = 1'b1;
      step();
    end
    chk("abort quiet", {31'b0, saw_done}, 32'd0);
    run8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "add0101");

    // WIDTH=16, DIGIT=4 with start held high for back-to-back operations.
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; sub16 = 1'b0; st16 = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("w16 busy", {31'b0, busy16}, 32'd1);
      chk("w16 early done", {31'b0, done16}, 32'd0);
      step();
    end
    chk("w16 done", {31'b0, done16}, 32'd1);
    chk("w16 sum", {16'b0, sum16}, 32'h0001);
    chk("w16 carry", {31'b0, carry16}, 32'd1);
    chk("w16 ovf", {31'b0, ovf16}, 32'd0);
    step();
    st16 = 1'b0;
    chk("w16 retrigger", {31'b0, busy16}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("w16 gap done", {31'b0, done16}, 32'd0);
      chk("w16 result hold", {16'b0, sum16}, 32'h0001);
      step();
    end
    chk("w16 gap done", {31'b0, done16}, 32'd0);
    step();
    chk("w16 second done", {31'b0, done16}, 32'd1);
    chk("w16 second sum", {16'b0, sum16}, 32'h0001);
    step();
    chk("w16 idle", {31'b0, busy16 | done16}, 32'd0);

    // WIDTH=8, DIGIT=8: a single digit cycle.
    a88 = 8'h7F; b88 = 8'h01; cin88 = 1'b0; sub88 = 1'b0; st88 = 1'b1;
    step();
    st88 = 1'b0;
    chk("w88 busy", {31'b0, busy88}, 32'd1);
    chk("w88 early done", {31'b0, done88}, 32'd0);
    step();
    chk("w88 done", {31'b0, done88}, 32'd1);
    chk("w88 sum", {24'b0, sum88}, 32'h80);
    chk("w88 ovf", {31'b0, ovf88}, 32'd1);
    chk("w88 carry", {31'b0, carry88}, 32'd0);
    step();
    chk("w88 done drop", {31'b0, done88}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
